// File: rtl/fifo_pkg.sv
// Shared constants and Gray-code helpers for the async FIFO read and write controllers.
package fifo_pkg;

    localparam int DEPTH  = 64;
    localparam int WIDTH  = 32;
    localparam int ADDR_W = 6;
    localparam int PTR_W  = ADDR_W + 1;

    // Operates on a zero-extended 32-bit value; callers cast the result back to pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin_val);
        return bin_val ^ (bin_val >> 1);
    endfunction

    // Upper bits are zero for narrower pointers, so the prefix XOR stays correct after truncation.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray_val);
        logic [31:0] bin_val;
        bin_val[31] = gray_val[31];
        for (int i = 30; i >= 0; i--) begin
            bin_val[i] = bin_val[i+1] ^ gray_val[i];
        end
        return bin_val;
    endfunction

endpackage

// File: rtl/fifo_gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into this clock domain.
module fifo_gray_sync #(
    parameter int WIDTH  = 7,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (STAGES < 2) begin : g_bad_stages
        $error("fifo_gray_sync needs at least two stages");
    end

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_d [STAGES];

    // Pure shift chain: each stage takes the previous one with no logic in between.
    always_comb begin
        sync_d[0] = din;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Synchroniser flops, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller: syncs the write pointer, fetches from the registered-read memory
// and presents words through a two-entry first-word-fall-through output buffer.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH       = 64,
    parameter int WIDTH       = 32,
    parameter int ADDR_W      = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic              r_clk,
    input  logic              r_rst_n,
    input  logic [ADDR_W:0]   w_ptr_gray,
    output logic [ADDR_W:0]   r_ptr_gray,
    output logic [ADDR_W-1:0] r_addr,
    output logic              r_valid,
    input  logic [WIDTH-1:0]  r_data,
    output logic [WIDTH-1:0]  dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              empty,
    output logic [ADDR_W:0]   r_level
);

    localparam int PTR_BITS = ADDR_W + 1;

    if (DEPTH != (1 << ADDR_W)) begin : g_bad_depth
        $error("DEPTH must equal 2**ADDR_W");
    end

    logic [ADDR_W:0]  wq_gray;
    logic [ADDR_W:0]  wq_bin;

    logic [ADDR_W:0]  r_ptr_bin_q,  r_ptr_bin_d;
    logic [ADDR_W:0]  r_ptr_gray_q, r_ptr_gray_d;
    logic             inflight_q,   inflight_d;
    logic [1:0]       buf_count_q,  buf_count_d;
    logic             head_q,       head_d;
    logic [WIDTH-1:0] buf_mem_q [2];
    logic [WIDTH-1:0] buf_mem_d [2];

    logic             pop;
    logic             issue;
    logic             tail;
    logic [2:0]       occ_after;

    fifo_gray_sync #(
        .WIDTH  (PTR_BITS),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk   (r_clk),
        .rst_n (r_rst_n),
        .din   (w_ptr_gray),
        .dout  (wq_gray)
    );

    assign wq_bin  = PTR_BITS'(gray2bin(32'(wq_gray)));
    assign empty   = (r_ptr_bin_q == wq_bin);
    assign r_level = wq_bin - r_ptr_bin_q;

    // Fetch decision: occupancy after this cycle (buffered + in flight - popped) must leave room.
    always_comb begin
        dout_valid = (buf_count_q != 2'd0);
        pop        = dout_valid & dout_ready;
        occ_after  = {1'b0, buf_count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue      = !empty && (occ_after < 3'd2);
    end

    // Next-state: advance the read pointer on fetch, capture returning data at the tail, pop the head.
    always_comb begin
        r_ptr_bin_d  = r_ptr_bin_q + {{ADDR_W{1'b0}}, issue};
        r_ptr_gray_d = PTR_BITS'(bin2gray(32'(r_ptr_bin_d)));
        inflight_d   = issue;
        // head + count modulo 2; with two entries and a pop the tail reuses the departing head slot
        tail         = head_q ^ buf_count_q[0];
        buf_mem_d[0] = buf_mem_q[0];
        buf_mem_d[1] = buf_mem_q[1];
        if (inflight_q) begin
            buf_mem_d[tail] = r_data;
        end
        head_d       = head_q ^ pop;
        buf_count_d  = occ_after[1:0];
    end

    // All state clears asynchronously; buffered and in-flight words are discarded.
    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_ptr_bin_q  <= '0;
            r_ptr_gray_q <= '0;
            inflight_q   <= 1'b0;
            buf_count_q  <= 2'd0;
            head_q       <= 1'b0;
            buf_mem_q[0] <= '0;
            buf_mem_q[1] <= '0;
        end else begin
            r_ptr_bin_q  <= r_ptr_bin_d;
            r_ptr_gray_q <= r_ptr_gray_d;
            inflight_q   <= inflight_d;
            buf_count_q  <= buf_count_d;
            head_q       <= head_d;
            buf_mem_q[0] <= buf_mem_d[0];
            buf_mem_q[1] <= buf_mem_d[1];
        end
    end

    assign r_ptr_gray = r_ptr_gray_q;
    assign r_addr     = r_ptr_bin_q[ADDR_W-1:0];
    assign r_valid    = issue;
    assign dout       = buf_mem_q[head_q];

    a_no_overflow:    assert property (@(posedge r_clk) disable iff (!r_rst_n) occ_after <= 3'd2);
    a_no_underflow:   assert property (@(posedge r_clk) disable iff (!r_rst_n) !(pop && buf_count_q == 2'd0));
    a_no_issue_empty: assert property (@(posedge r_clk) disable iff (!r_rst_n) !(issue && empty));

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: directed scenarios plus a per-cycle scoreboard model.
module tb_fifo_rd_ctrl;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          r_clk = 1'b0;
    logic          r_rst_n = 1'b0;
    logic [AW:0]   w_ptr_gray = '0;
    logic [AW:0]   r_ptr_gray;
    logic [AW-1:0] r_addr;
    logic          r_valid;
    logic [DW-1:0] r_data;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic          empty;
    logic [AW:0]   r_level;

    logic [DW-1:0] mem [64];

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard/model state
    logic [31:0] exp_q [$];
    int          total_iss = 0;
    int          popped = 0;
    int          h1 = 0;
    int          h2 = 0;
    logic [6:0]  wh1 = '0;
    logic [6:0]  wh2 = '0;
    bit          prev_hold = 0;
    logic [31:0] prev_dout = '0;
    int          wcnt = 0;

    always #5 r_clk = ~r_clk;

    fifo_rd_ctrl #(
        .DEPTH       (64),
        .WIDTH       (DW),
        .ADDR_W      (AW),
        .SYNC_STAGES (2)
    ) dut (
        .r_clk      (r_clk),
        .r_rst_n    (r_rst_n),
        .w_ptr_gray (w_ptr_gray),
        .r_ptr_gray (r_ptr_gray),
        .r_addr     (r_addr),
        .r_valid    (r_valid),
        .r_data     (r_data),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .empty      (empty),
        .r_level    (r_level)
    );

    // Registered-read memory: data appears one clock after the fetch.
    always @(posedge r_clk) begin
        if (r_valid) r_data <= mem[r_addr];
    end

    function automatic logic [6:0] gray7(input int b);
        logic [6:0] x;
        x = b[6:0];
        return x ^ (x >> 1);
    endfunction

    function automatic logic [6:0] g2b7(input logic [6:0] g);
        logic [6:0] b;
        for (int i = 0; i < 7; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge r_clk);
        #1;
    endtask

    task automatic push_words(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            mem[wcnt % 64] = base + i;
            exp_q.push_back(base + i);
            wcnt++;
        end
        w_ptr_gray = gray7(wcnt);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || dout_valid) && t < 600) begin
            tick(1);
            t++;
        end
        check({name, "_drain_timeout"}, 32'(t < 600), 32'd1);
    endtask

    task automatic do_reset();
        @(posedge r_clk);
        #3;
        r_rst_n = 1'b0;
        w_ptr_gray = '0;
        wcnt = 0;
        tick(3);
        r_rst_n = 1'b1;
    endtask

    // Per-cycle compare against the counting model (negedge, away from the active edge).
    initial begin
        forever begin
            @(negedge r_clk);
            if (!r_rst_n) begin
                check("rst_r_valid", 32'(r_valid), 32'd0);
                check("rst_dout_valid", 32'(dout_valid), 32'd0);
                exp_q.delete();
                total_iss = 0; popped = 0; h1 = 0; h2 = 0;
                wh1 = '0; wh2 = '0;
                prev_hold = 0;
            end else begin
                logic [6:0] lvl;
                int         avail;
                bit         popnow;
                lvl = g2b7(wh2) - 7'(total_iss);
                check("r_level", 32'(r_level), 32'(lvl));
                check("empty", 32'(empty), 32'(lvl == 7'd0));
                check("r_ptr_gray", 32'(r_ptr_gray), 32'(gray7(total_iss)));
                avail = h2 - popped;
                check("dout_valid", 32'(dout_valid), 32'(avail > 0));
                if (prev_hold) check("hold_dout", dout, prev_dout);
                popnow = dout_valid && dout_ready;
                check("r_valid", 32'(r_valid),
                      32'((lvl != 7'd0) && ((total_iss - popped - int'(popnow)) < 2)));
                if (r_valid) check("r_addr", 32'(r_addr), 32'(total_iss % 64));
                if (popnow) begin
                    if (exp_q.size() == 0) check("pop_unexpected", 32'd1, 32'd0);
                    else check("dout_data", dout, exp_q.pop_front());
                    popped++;
                end
                prev_hold = dout_valid && !dout_ready;
                prev_dout = dout;
                if (r_valid) total_iss++;
                h2 = h1; h1 = total_iss;
                wh2 = wh1; wh1 = w_ptr_gray;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  pulses;
        bit  seen_wrap;
        logic [6:0] prev_g;
        int  t;

        // Idle
        tick(3);
        r_rst_n = 1'b1;
        tick(6);
        check("idle_empty", 32'(empty), 32'd1);
        check("idle_level", 32'(r_level), 32'd0);
        check("idle_dout_valid", 32'(dout_valid), 32'd0);
        check("idle_r_valid", 32'(r_valid), 32'd0);
        check("idle_r_ptr_gray", 32'(r_ptr_gray), 32'd0);
        check("idle_dout", dout, 32'd0);

        // Single word: latency from the first sampling edge
        push_words(1, 32'hDEADBEEF);
        tick(1);
        check("sw_e0_dout_valid", 32'(dout_valid), 32'd0);
        check("sw_e0_empty", 32'(empty), 32'd1);
        tick(1);
        check("sw_e1_empty", 32'(empty), 32'd0);
        check("sw_e1_r_valid", 32'(r_valid), 32'd1);
        check("sw_e1_r_addr", 32'(r_addr), 32'd0);
        check("sw_e1_level", 32'(r_level), 32'd1);
        tick(1);
        check("sw_e2_dout_valid", 32'(dout_valid), 32'd0);
        check("sw_e2_empty", 32'(empty), 32'd1);
        check("sw_e2_r_ptr_gray", 32'(r_ptr_gray), 32'h01);
        check("sw_e2_r_valid", 32'(r_valid), 32'd0);
        tick(1);
        check("sw_e3_dout_valid", 32'(dout_valid), 32'd1);
        check("sw_e3_dout", dout, 32'hDEADBEEF);
        dout_ready = 1'b1;
        tick(1);
        check("sw_popped_dout_valid", 32'(dout_valid), 32'd0);

        // Burst: 64 words, values = index, full write side
        do_reset();
        push_words(64, 32'd0);
        dout_ready = 1'b1;
        t = 0;
        while (!dout_valid && t < 20) begin tick(1); t++; end
        check("burst_start_timeout", 32'(t < 20), 32'd1);
        for (int i = 0; i < 64; i++) begin
            check("burst_valid", 32'(dout_valid), 32'd1);
            check("burst_data", dout, 32'(i));
            tick(1);
        end
        check("burst_end_valid", 32'(dout_valid), 32'd0);
        check("burst_r_ptr_gray", 32'(r_ptr_gray), 32'h60);
        check("burst_level", 32'(r_level), 32'd0);
        check("burst_empty", 32'(empty), 32'd1);

        // Backpressure: 10 words, consumer stalled
        dout_ready = 1'b0;
        push_words(10, 32'h1000);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            if (r_valid) pulses++;
            tick(1);
        end
        check("bp_pulses", 32'(pulses), 32'd2);
        check("bp_level", 32'(r_level), 32'd8);
        check("bp_dout_valid", 32'(dout_valid), 32'd1);
        check("bp_dout", dout, 32'h1000);
        check("bp_r_ptr_gray", 32'(r_ptr_gray), 32'h63);
        dout_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_stream_valid", 32'(dout_valid), 32'd1);
            check("bp_stream_data", dout, 32'h1000 + 32'(i));
            tick(1);
        end
        check("bp_end_valid", 32'(dout_valid), 32'd0);

        // Wrap: read pointer runs through 127 -> 0
        push_words(50, 32'h2000);
        drain("wrap1");
        push_words(10, 32'h3000);
        seen_wrap = 0;
        prev_g = r_ptr_gray;
        t = 0;
        while ((exp_q.size() != 0 || dout_valid) && t < 600) begin
            tick(1);
            t++;
            if (prev_g == 7'b1000000 && r_ptr_gray == 7'b0000000) seen_wrap = 1;
            prev_g = r_ptr_gray;
        end
        check("wrap_drain_timeout", 32'(t < 600), 32'd1);
        check("wrap_seen", 32'(seen_wrap), 32'd1);
        check("wrap_r_ptr_gray", 32'(r_ptr_gray), 32'h05);
        check("wrap_empty", 32'(empty), 32'd1);
        check("wrap_level", 32'(r_level), 32'd0);

        // Reset mid-burst
        push_words(40, 32'h4000);
        tick(6);
        @(posedge r_clk);
        #3;
        r_rst_n = 1'b0;
        w_ptr_gray = '0;
        wcnt = 0;
        #1;
        check("mr_dout_valid", 32'(dout_valid), 32'd0);
        check("mr_r_valid", 32'(r_valid), 32'd0);
        check("mr_empty", 32'(empty), 32'd1);
        check("mr_level", 32'(r_level), 32'd0);
        check("mr_r_ptr_gray", 32'(r_ptr_gray), 32'd0);
        check("mr_dout", dout, 32'd0);
        tick(3);
        r_rst_n = 1'b1;
        tick(4);
        push_words(3, 32'h5000);
        drain("post_rst");
        check("post_rst_r_ptr_gray", 32'(r_ptr_gray), 32'h02);
        check("post_rst_empty", 32'(empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
